mac_sequencer: RTL and testbench
================================

# mac_sequencer

Synthesizable, parametrised successor to the bench-driven operand feeding around `mac_datapath`/`mac_controller`. It holds a DEPTH-entry operand buffer and walks the first `len` entries through an internal multiply-accumulate. Each step's result goes into a readable result buffer, and a one-cycle `done` pulse marks the end of a run. It replaces file/bench sequencing of operand pairs with an in-fabric block usable by any master.

## Interface
- DATA_W, 8, operand width (unsigned)
- DEPTH, 4, operand/result buffer entries (≥1)
- AW, $clog2(DEPTH) (min 1), address width
- ACC_W, 2*DATA_W+$clog2(DEPTH), accumulator/result width (≥2*DATA_W)

- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-low reset
- wr_en  input  1  write operand pair
- wr_addr  input  AW  operand entry
- wr_a, wr_b  input  DATA_W  operands
- len  input  AW+1  entries to process, sampled with start
- mode  input  1  0 = accumulate, 1 = independent products; sampled with start
- start  input  1  begin run (level-sampled in IDLE only)
- busy  output  1  high from the cycle after start until DONE ends
- done  output  1  one-cycle pulse in DONE
- acc_out  output  ACC_W  final accumulator value, held until next start
- overflow  output  1  sticky; some step exceeded ACC_W; cleared on start
- rd_addr  input  AW  result entry
- rd_data  output  ACC_W  result[rd_addr], registered

## Operation
- States: IDLE, FETCH, MUL, ACC, DONE.
- IDLE:
  - On start, latch len (clamped to DEPTH), latch mode, clear acc/overflow, set index i=0.
  - Go to FETCH, or to DONE if len=0.
- Each entry takes three cycles:
  - FETCH: registered read of operand[i].
  - MUL: product register = a*b, 2*DATA_W bits, zero-extended to ACC_W.
  - ACC: compute the step value, write it to result[i], then i++. Go to FETCH if i<len, else DONE.
- Step value:
  - mode 0: acc+product.
  - mode 1: product only; acc takes the product.
- Overflow: a carry out of ACC_W sets `overflow`. The stored value is set by MAC_SAT_EN.
- DONE: done=1, acc_out updated, then IDLE.
- wr_en is ignored while busy. Operand writes in IDLE take effect the next cycle.
- start is ignored outside IDLE.
- Result buffer is read-only to users and written only in ACC. Entries ≥len keep prior contents.
- Reset:
  - Cleared: state→IDLE, busy/done/overflow 0, acc/acc_out 0, rd_data 0.
  - Not cleared: operand and result buffers.
  - Reset mid-run aborts the run immediately with no done pulse.

## Timing
- Start sampled at edge k: DONE entered at edge k+3*len, so done is high in cycle k+3*len to k+3*len+1.
- len=0: DONE entered at edge k.
- busy is high from edge k until the edge leaving DONE.
- result[i] is written at edge k+3*i+3.
- rd_data: one-cycle latency from rd_addr. A read of an entry written on the same edge returns the old value.
- No combinational path from inputs to outputs.

## Configuration
- MAC_SAT_EN defined: on overflow, step value saturates to all-ones (2^ACC_W−1). A saturated acc stays saturated for the rest of the run in mode 0.
- MAC_SAT_EN undefined: step value wraps modulo 2^ACC_W.
- `overflow` is set in both builds.

## Structure
- Package `mac_seq_pkg`:
  - state enum (IDLE, FETCH, MUL, ACC, DONE)
  - mode constants MODE_ACC=0, MODE_PROD=1
- Sub-module `mac_unit`: product register, accumulator, overflow detect and the MAC_SAT_EN saturation logic. Ports: clk, rst, clr, mul_en, acc_en, mode, a, b, acc, ovf.
- Top level holds the FSM, index counter, and both buffers.

## Test plan
- Defaults, pairs (3,4),(5,6),(7,8),(2,9), len=4, mode 0 → result 12,42,98,116; acc_out=116; done 12 cycles after start; overflow=0.
- Same operands, mode 1 → result 12,30,56,18; acc_out=18.
- len=0 → done in cycle after start, busy one cycle, acc_out=0; result buffer unchanged.
- ACC_W=16, four pairs (255,255), mode 0 → overflow=1.
  - with MAC_SAT_EN: acc_out=65535, results 65025,65535,65535,65535
  - without: results 65025,64514,64003,63492; acc_out=63492
- len=7 with DEPTH=4 → clamped to 4 entries, done at 12 cycles. During the run, start and wr_en to entry 0 are ignored: operand 0 is unchanged, and there is no second run.
- rst low 5 cycles after start → next cycle busy=0, done=0, acc_out=0, state IDLE. Then a fresh start runs cleanly: test-1 values are reproduced.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types for the operand-buffer MAC sequencer: FSM state encoding and
// step-mode constants.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MUL   = 3'd2,
    ACC   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic MODE_ACC  = 1'b0;
  localparam logic MODE_PROD = 1'b1;

endpackage

// File: rtl/mac_unit.sv
// Product register, accumulator and sticky overflow for the MAC sequencer.
// Build option MAC_SAT_EN: overflowing steps saturate instead of wrapping.
module mac_unit
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              mul_en,
  input  logic              acc_en,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

`ifdef MAC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W:0]      prod_ext, sum;
  logic                carry;

  // acc presents the step value that the next acc_en edge commits
  always_comb begin
    prod_ext = {{(ACC_W + 1 - 2 * DATA_W){1'b0}}, prod_q};
    if (mode == MODE_PROD) begin
      sum = prod_ext;
    end else begin
      sum = {1'b0, acc_q} + prod_ext;
    end
    carry = sum[ACC_W];
    if (carry && SAT_EN) begin
      acc = {ACC_W{1'b1}};
    end else begin
      acc = sum[ACC_W-1:0];
    end

    if (mul_en) begin
      prod_d = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    end else begin
      prod_d = prod_q;
    end

    if (clr) begin
      acc_d = {ACC_W{1'b0}};
      ovf_d = 1'b0;
    end else if (acc_en) begin
      acc_d = acc;
      ovf_d = ovf_q | carry;
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q <= {(2 * DATA_W){1'b0}};
      acc_q  <= {ACC_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/mac_sequencer.sv
// Operand buffer walked through a multiply-accumulate, one entry per three
// cycles, with a readable result buffer. Saturation is selected by MAC_SAT_EN.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int ACC_W  = 2 * DATA_W + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [AW:0]       len,
  input  logic              mode,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  input  logic [AW-1:0]     rd_addr,
  output logic [ACC_W-1:0]  rd_data
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [AW:0]         idx_q, idx_d, len_q, len_d, len_clamp, idx_next;
  logic                mode_q, mode_d, busy_q, busy_d, done_q, done_d;
  logic [ACC_W-1:0]    acc_out_q, acc_out_d, rd_data_q, rd_data_d, step;
  logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic                start_ok, op_we, res_we, mul_en, acc_en, ovf;

  logic [DATA_W-1:0]   op_a_mem [DEPTH];
  logic [DATA_W-1:0]   op_b_mem [DEPTH];
  logic [ACC_W-1:0]    res_mem  [DEPTH];

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .rst(rst), .clr(start_ok), .mul_en(mul_en), .acc_en(acc_en),
    .mode(mode_q), .a(op_a_q), .b(op_b_q), .acc(step), .ovf(ovf)
  );

  // Next-state, index and output-register computation
  always_comb begin
    start_ok  = (state_q == IDLE) && start;
    len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    idx_next  = idx_q + {{AW{1'b0}}, 1'b1};
    op_we     = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    res_we    = (state_q == ACC);
    mul_en    = (state_q == MUL);
    acc_en    = (state_q == ACC);
    if ({1'b0, rd_addr} < DEPTH_L) begin
      rd_data_d = res_mem[rd_addr];
    end else begin
      rd_data_d = {ACC_W{1'b0}};
    end

    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_out_d = acc_out_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len_clamp;
          mode_d    = mode;
          idx_d     = {(AW + 1){1'b0}};
          acc_out_d = {ACC_W{1'b0}};
          busy_d    = 1'b1;
          if (len_clamp == {(AW + 1){1'b0}}) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      FETCH: begin
        op_a_d  = op_a_mem[idx_q[AW-1:0]];
        op_b_d  = op_b_mem[idx_q[AW-1:0]];
        state_d = MUL;
      end
      MUL: begin
        state_d = ACC;
      end
      ACC: begin
        idx_d = idx_next;
        if (idx_next < len_q) begin
          state_d = FETCH;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          acc_out_d = step;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= {(AW + 1){1'b0}};
      len_q     <= {(AW + 1){1'b0}};
      mode_q    <= MODE_ACC;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_out_q <= {ACC_W{1'b0}};
      rd_data_q <= {ACC_W{1'b0}};
      op_a_q    <= {DATA_W{1'b0}};
      op_b_q    <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_out_q <= acc_out_d;
      rd_data_q <= rd_data_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  // Buffers keep their contents across reset
  always_ff @(posedge clk) begin
    if (op_we) begin
      op_a_mem[wr_addr] <= wr_a;
      op_b_mem[wr_addr] <= wr_b;
    end
    if (res_we) begin
      res_mem[idx_q[AW-1:0]] <= step;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign acc_out  = acc_out_q;
  assign overflow = ovf;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: directed runs plus random runs checked
// against a plain-arithmetic model of the operand/result buffers.
module tb_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;
  localparam int ACC_W  = 16;
  localparam longint unsigned MAXV = 64'd1 << ACC_W;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, wr_en, mode, start;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_a, wr_b;
  logic [AW:0]       len;
  logic              busy, done, overflow;
  logic [ACC_W-1:0]  acc_out, rd_data;

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a),
    .wr_b(wr_b), .len(len), .mode(mode), .start(start), .busy(busy),
    .done(done), .acc_out(acc_out), .overflow(overflow), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  typedef struct {
    longint unsigned acc;
    bit              ovf;
    int unsigned     cyc;
  } exp_t;

  exp_t            sb_q[$];
  longint unsigned rd_q[$];
  int unsigned     op_a_m[DEPTH];
  int unsigned     op_b_m[DEPTH];
  longint unsigned res_m[DEPTH];
  bit              res_v[DEPTH];
  int unsigned     cyc = 0;
  int unsigned     busy_cnt = 0;
  int unsigned     busy_base = 0;
  bit              rd_req = 1'b0;
  bit              rd_seen = 1'b0;
  int              vectors = 0;
  int              miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= rd_req;
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents done or read data
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("acc_out", acc_out, e.acc);
        chk("overflow", overflow, e.ovf);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", busy, 1'b1);
      end
    end
    if (rd_seen && rd_q.size() > 0) begin
      chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  // Reference: run the clamped entries with plain arithmetic
  task automatic run_model(input int len_in, input bit mode_in,
                           output longint unsigned acc, output bit ovf);
    int n;
    longint unsigned p, v;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(op_a_m[i]) * longint'(op_b_m[i]);
      v = mode_in ? p : acc + p;
      if (v >= MAXV) begin
        ovf = 1'b1;
        v = SAT ? MAXV - 1 : v % MAXV;
      end
      acc = v;
      res_m[i] = v;
      res_v[i] = 1'b1;
    end
  endtask

  task automatic write_op(input int addr, input int unsigned a, input int unsigned b);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_a = DATA_W'(a); wr_b = DATA_W'(b);
    op_a_m[addr] = a;
    op_b_m[addr] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int len_in, input bit mode_in, input bit expect_done);
    longint unsigned acc;
    bit ovf;
    int n;
    exp_t e;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    if (expect_done) begin
      run_model(len_in, mode_in, acc, ovf);
      e.acc = acc; e.ovf = ovf; e.cyc = cyc + 1 + 3 * n;
      sb_q.push_back(e);
    end
    busy_base = busy_cnt;
    start = 1'b1; len = (AW + 1)'(len_in); mode = mode_in;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int len_in);
    int n = 0;
    int m;
    m = (len_in > DEPTH) ? DEPTH : len_in;
    while (sb_q.size() > 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) begin
      chk("done_timeout", n, 0);
      sb_q.delete();
    end
    chk("busy_after_done", busy, 1'b0);
    chk("busy_cycles", busy_cnt - busy_base, 3 * m + 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      if (res_v[i]) begin
        rd_addr = AW'(i);
        rd_req = 1'b1;
        rd_q.push_back(res_m[i]);
        @(posedge clk); #1;
      end
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_base();
    write_op(0, 3, 4);
    write_op(1, 5, 6);
    write_op(2, 7, 8);
    write_op(3, 2, 9);
  endtask

  initial begin
    longint unsigned old0;
    rst = 1'b0; wr_en = 1'b0; mode = 1'b0; start = 1'b0; len = '0;
    wr_addr = '0; wr_a = '0; wr_b = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) res_v[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    load_base();
    start_run(4, 1'b0, 1'b1); wait_done(4); read_all();
    start_run(4, 1'b1, 1'b1); wait_done(4); read_all();
    start_run(0, 1'b0, 1'b1); wait_done(0); read_all();

    // Overflow run; also read entry 0 across the edge that rewrites it
    old0 = res_m[0];
    for (int i = 0; i < DEPTH; i++) write_op(i, 255, 255);
    start_run(4, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rd_addr = '0; rd_req = 1'b1; rd_q.push_back(old0);
    @(posedge clk); #1;
    rd_q.push_back(res_m[0]);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_done(4); read_all();

    // Clamped length; start and operand write during the run are ignored
    load_base();
    start_run(7, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; len = 3'd1; mode = 1'b1;
    wr_en = 1'b1; wr_addr = '0; wr_a = 8'd99; wr_b = 8'd99;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done(7);
    repeat (10) @(posedge clk);
    #1;
    chk("no_second_run", busy, 1'b0);
    start_run(1, 1'b1, 1'b1); wait_done(1); read_all();

    // Reset mid-run aborts; a fresh run then reproduces the base results
    start_run(4, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_acc_out", acc_out, 0);
    chk("abort_overflow", overflow, 1'b0);
    res_m[0] = longint'(op_a_m[0]) * longint'(op_b_m[0]);
    repeat (15) @(posedge clk);
    #1;
    start_run(4, 1'b0, 1'b1); wait_done(4); read_all();

    for (int r = 0; r < 16; r++) begin
      int nw, ln;
      bit md;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        write_op($urandom_range(0, DEPTH - 1), $urandom_range(0, 255), $urandom_range(0, 255));
      ln = $urandom_range(0, 7);
      md = 1'($urandom_range(0, 1));
      start_run(ln, md, 1'b1);
      wait_done(ln);
      read_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
